// File: rtl/gbt_link_monitor.sv
// Link qualifier: debounces GBT link status and MMCM lock into a single link-good level,
// emits up/lost strobes, and keeps saturating loss/glitch counters for slow control.
module gbt_link_monitor #(
    parameter int SETTLE_CNT_MAX = 2**12-1,
    parameter int DROP_TOLERANCE = 2,
    parameter int CNT_BITS       = 16
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                mmcms_locked_i,
    input  logic                gbt_rxready_i,
    input  logic                gbt_rxvalid_i,
    input  logic                gbt_txready_i,
    input  logic                cnt_clear_i,
    output logic                link_good_o,
    output logic                link_up_o,
    output logic                link_lost_o,
    output logic [1:0]          link_state_o,
    output logic [CNT_BITS-1:0] unlock_cnt_o,
    output logic [CNT_BITS-1:0] glitch_cnt_o
);

    localparam int SETTLE_W = (SETTLE_CNT_MAX > 0) ? $clog2(SETTLE_CNT_MAX + 1) : 1;
    localparam int BAD_W    = (DROP_TOLERANCE > 0) ? $clog2(DROP_TOLERANCE + 1) : 1;

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CNT_MAX);
    localparam logic [BAD_W-1:0]    BAD_LAST    = BAD_W'(DROP_TOLERANCE);

    typedef enum logic [1:0] {
        ST_DOWN   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_UP     = 2'd2,
        ST_GRACE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [BAD_W-1:0]    bad_cnt_q, bad_cnt_d;
    logic [CNT_BITS-1:0] unlock_cnt_q, unlock_cnt_d;
    logic [CNT_BITS-1:0] glitch_cnt_q, glitch_cnt_d;
    logic                link_good_q, link_good_d;
    logic                link_up_q, link_up_d;
    logic                link_lost_q, link_lost_d;

    logic good;
    logic glitch_evt;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + CNT_BITS'(1);
    endfunction

    assign good = mmcms_locked_i & gbt_rxready_i & gbt_rxvalid_i & gbt_txready_i;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        link_up_d    = 1'b0;
        link_lost_d  = 1'b0;
        glitch_evt   = 1'b0;

        case (state_q)
            ST_DOWN: begin
                if (good) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (!good) begin
                    state_d = ST_DOWN;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d   = ST_UP;
                    link_up_d = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end
            end
            ST_UP: begin
                if (!good) begin
                    // Losing the MMCM lock bypasses the grace window entirely.
                    if (DROP_TOLERANCE == 0 || !mmcms_locked_i) begin
                        state_d     = ST_DOWN;
                        link_lost_d = 1'b1;
                    end else begin
                        state_d   = ST_GRACE;
                        bad_cnt_d = BAD_W'(1);
                    end
                end
            end
            ST_GRACE: begin
                if (good) begin
                    state_d    = ST_UP;
                    glitch_evt = 1'b1;
                end else if (!mmcms_locked_i || bad_cnt_q >= BAD_LAST) begin
                    state_d     = ST_DOWN;
                    link_lost_d = 1'b1;
                end else begin
                    bad_cnt_d = bad_cnt_q + BAD_W'(1);
                end
            end
            default: begin
                state_d = ST_DOWN;
            end
        endcase

        link_good_d = (state_d == ST_UP) || (state_d == ST_GRACE);

        // A clear strobe takes priority over any increment on the same edge.
        unlock_cnt_d = unlock_cnt_q;
        glitch_cnt_d = glitch_cnt_q;
        if (cnt_clear_i) begin
            unlock_cnt_d = '0;
            glitch_cnt_d = '0;
        end else begin
            if (link_lost_d) unlock_cnt_d = sat_inc(unlock_cnt_q);
            if (glitch_evt)  glitch_cnt_d = sat_inc(glitch_cnt_q);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_DOWN;
            settle_cnt_q <= '0;
            bad_cnt_q    <= '0;
            unlock_cnt_q <= '0;
            glitch_cnt_q <= '0;
            link_good_q  <= 1'b0;
            link_up_q    <= 1'b0;
            link_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            unlock_cnt_q <= unlock_cnt_d;
            glitch_cnt_q <= glitch_cnt_d;
            link_good_q  <= link_good_d;
            link_up_q    <= link_up_d;
            link_lost_q  <= link_lost_d;
        end
    end

    assign link_good_o  = link_good_q;
    assign link_up_o    = link_up_q;
    assign link_lost_o  = link_lost_q;
    assign link_state_o = state_q;
    assign unlock_cnt_o = unlock_cnt_q;
    assign glitch_cnt_o = glitch_cnt_q;

    // Strobes are exclusive single-cycle pulses; link-good tracks the UP/GRACE half of the encoding.
    a_strobe_excl: assert property (@(posedge clock_i) disable iff (reset_i)
        !(link_up_q && link_lost_q));
    a_up_single: assert property (@(posedge clock_i) disable iff (reset_i)
        link_up_q |=> !link_up_q);
    a_lost_single: assert property (@(posedge clock_i) disable iff (reset_i)
        link_lost_q |=> !link_lost_q);
    a_good_state: assert property (@(posedge clock_i) disable iff (reset_i)
        link_good_q == state_q[1]);

endmodule
